bmem_arbiter: RTL and testbench



---
 rtl/bmem_arbiter_if.sv | 40 ++++
 rtl/bmem_arbiter.sv | 155 +++++++++++++++
 tb/tb_bmem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bmem_arbiter_if.sv
// Bundle of every signal between bmem_arbiter, the two cache dfp ports and
// the bmem pins. The arbiter uses the slave view. The master view is the
// environment side: caches drive requests and memory drives beats/ready.
interface bmem_arbiter_if;
    // icache side
    logic [31:0]  i_addr;
    logic         i_read;
    logic [255:0] i_rdata;
    logic         i_resp;
    // dcache side
    logic [31:0]  d_addr;
    logic         d_read;
    logic         d_write;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    // burst memory side
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    modport slave (
        input  i_addr, i_read, d_addr, d_read, d_write, d_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        output i_rdata, i_resp, d_rdata, d_resp,
        output bmem_addr, bmem_read, bmem_write, bmem_wdata
    );

    modport master (
        output i_addr, i_read, d_addr, d_read, d_write, d_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        input  i_rdata, i_resp, d_rdata, d_resp,
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata
    );
endinterface

// File: rtl/bmem_arbiter.sv
// Shares the single 64-bit burst memory port between icache and dcache.
// One line transfer at a time: reads are issued as one command and
// assembled from 4 address-tagged beats, dcache writebacks are sent as
// 4 beats. Ties are broken round-robin against the last served cache.
module bmem_arbiter (
    input  logic           clk,
    input  logic           rst,
    bmem_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        WR       = 3'd3,
        RESP     = 3'd4
    } state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

    state_t          r_state, w_state_next;
    gnt_t            r_gnt, w_gnt_next;
    gnt_t            r_last, w_last_next;
    logic [31:0]     r_line, w_line_next;
    logic [1:0]      r_cnt, w_cnt_next;
    logic [3:0][63:0] r_buf;

    logic            w_i_req;
    logic            w_d_req;
    logic            w_pick_d;
    logic            w_beat_store;
    logic [3:0]      w_lane_we;
    logic [63:0]     w_wbeat [4];
    logic            w_unused_bits;

    // Offset bits inside the line are irrelevant: transfers are whole lines.
    assign w_unused_bits = ^{bus.i_addr[4:0], bus.d_addr[4:0]};

    assign w_i_req  = bus.i_read;
    assign w_d_req  = bus.d_read | bus.d_write;
    // Lone requester wins; on a tie the one not served last wins.
    assign w_pick_d = w_d_req && (!w_i_req || (r_last == GNT_I));

    // Write-beat slicing of the dcache line and per-lane read-buffer enables.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_wbeat[gi]   = bus.d_wdata[gi*64 +: 64];
            assign w_lane_we[gi] = w_beat_store && (r_cnt == 2'(gi));
        end
    endgenerate

    // State, grant, round-robin, line address and beat counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= GNT_I;
            r_last  <= GNT_I;
            r_line  <= 32'd0;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_gnt   <= w_gnt_next;
            r_last  <= w_last_next;
            r_line  <= w_line_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic: grant in IDLE, then issue/collect or stream beats.
    always_comb begin
        w_state_next = r_state;
        w_gnt_next   = r_gnt;
        w_last_next  = r_last;
        w_line_next  = r_line;
        w_cnt_next   = r_cnt;
        w_beat_store = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_next = 2'd0;
                if (w_i_req || w_d_req) begin
                    if (w_pick_d) begin
                        w_gnt_next   = GNT_D;
                        w_line_next  = {bus.d_addr[31:5], 5'b0};
                        // A writeback takes priority over a read from dcache.
                        w_state_next = bus.d_write ? WR : RD_ISSUE;
                    end else begin
                        w_gnt_next   = GNT_I;
                        w_line_next  = {bus.i_addr[31:5], 5'b0};
                        w_state_next = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                if (bus.bmem_ready) begin
                    w_state_next = RD_WAIT;
                    w_cnt_next   = 2'd0;
                end
            end
            RD_WAIT: begin
                // Beats tagged with another line are stale and dropped.
                if (bus.bmem_rvalid && (bus.bmem_raddr == r_line)) begin
                    w_beat_store = 1'b1;
                    w_cnt_next   = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        w_state_next = RESP;
                    end
                end
            end
            WR: begin
                // Hold the current beat until memory accepts it.
                if (bus.bmem_ready) begin
                    w_cnt_next = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        w_state_next = RESP;
                    end
                end
            end
            RESP: begin
                w_last_next  = r_gnt;
                w_cnt_next   = 2'd0;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Read line buffer: one 64-bit lane captured per matched beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_lane_we[k]) begin
                    r_buf[k] <= bus.bmem_rdata;
                end
            end
        end
    end

    assign bus.bmem_addr  = (r_state == IDLE) ? 32'd0 : r_line;
    assign bus.bmem_read  = (r_state == RD_ISSUE);
    assign bus.bmem_write = (r_state == WR);
    assign bus.bmem_wdata = (r_state == WR) ? w_wbeat[r_cnt] : 64'd0;
    assign bus.i_resp     = (r_state == RESP) && (r_gnt == GNT_I);
    assign bus.d_resp     = (r_state == RESP) && (r_gnt == GNT_D);
    assign bus.i_rdata    = r_buf;
    assign bus.d_rdata    = r_buf;

endmodule

// File: tb/tb_bmem_arbiter.sv
// Directed bench for bmem_arbiter. The bench plays both caches and the burst
// memory; expected responses, read commands and write beats are queued when
// a request is driven and checked as the arbiter produces them.
module tb_bmem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bmem_arbiter_if bus();

    bmem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic         is_d;
        logic         is_read;
        logic [255:0] data;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
    } beat_t;

    resp_t       resp_q[$];
    beat_t       wbeat_q[$];
    logic [31:0] rdcmd_q[$];
    beat_t       rbeat_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ready_mode = 0;
    bit ready_phase = 1'b0;
    bit inject_bad  = 1'b0;
    int rbeats_sent = 0;
    int cmd_cyc = 0;
    int last_beat_cyc = 0;
    int last_resp_cyc = 0;
    int first_wb_cyc = 0;
    int last_wb_cyc = 0;
    int n_wacc = 0;
    int n_wcyc = 0;

    localparam logic [255:0] LINE_1ECEB = {64'h4444444444444444, 64'h3333333333333333,
                                           64'h2222222222222222, 64'h1111111111111111};

    function automatic logic [63:0] mem_word(input logic [31:0] line, input int k);
        if (line == 32'h1eceb000) return 64'h1111111111111111 * 64'(k + 1);
        return {line, 32'hc0de0000 | 32'(k)};
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] line);
        return {mem_word(line, 3), mem_word(line, 2), mem_word(line, 1), mem_word(line, 0)};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_read(input logic is_d, input logic [31:0] line, input logic [255:0] data);
        resp_t r;
        r.is_d = is_d; r.is_read = 1'b1; r.data = data;
        resp_q.push_back(r);
        rdcmd_q.push_back(line);
    endtask

    task automatic exp_write(input logic [31:0] line, input logic [255:0] wd);
        resp_t r;
        beat_t b;
        for (int k = 0; k < 4; k++) begin
            b.addr = line; b.data = wd[k*64 +: 64];
            wbeat_q.push_back(b);
        end
        r.is_d = 1'b1; r.is_read = 1'b0; r.data = '0;
        resp_q.push_back(r);
    endtask

    // One clock: sample outputs 1 ns after the negedge, play memory, advance.
    task automatic tick();
        resp_t r;
        beat_t b;
        #1;
        if (bus.i_resp || bus.d_resp) begin
            if (resp_q.size() == 0) begin
                chk("unexpected_resp", 256'({bus.i_resp, bus.d_resp}), 256'(0));
            end else begin
                r = resp_q.pop_front();
                chk("resp_d_port", 256'(bus.d_resp), 256'(r.is_d));
                chk("resp_i_port", 256'(bus.i_resp), 256'(!r.is_d));
                if (r.is_read) begin
                    if (r.is_d) chk("d_rdata", bus.d_rdata, r.data);
                    else        chk("i_rdata", bus.i_rdata, r.data);
                end
            end
            last_resp_cyc = cyc;
            if (bus.i_resp) bus.i_read = 1'b0;
            if (bus.d_resp) begin
                bus.d_read  = 1'b0;
                bus.d_write = 1'b0;
            end
        end
        if (ready_mode == 0) begin
            bus.bmem_ready = 1'b1;
        end else begin
            bus.bmem_ready = ready_phase;
            ready_phase = !ready_phase;
        end
        if (rbeat_q.size() > 0) begin
            b = rbeat_q.pop_front();
            bus.bmem_rvalid = 1'b1;
            bus.bmem_raddr  = b.addr;
            bus.bmem_rdata  = b.data;
            rbeats_sent++;
            last_beat_cyc = cyc;
        end else begin
            bus.bmem_rvalid = 1'b0;
            bus.bmem_raddr  = 32'd0;
            bus.bmem_rdata  = 64'd0;
        end
        if (bus.bmem_read && bus.bmem_ready) begin
            cmd_cyc = cyc;
            if (rdcmd_q.size() == 0) begin
                chk("unexpected_read", 256'(bus.bmem_read), 256'(0));
            end else begin
                chk("rd_addr", 256'(bus.bmem_addr), 256'(rdcmd_q.pop_front()));
            end
            for (int k = 0; k < 4; k++) begin
                if (inject_bad && k == 2) begin
                    b.addr = bus.bmem_addr ^ 32'h20; b.data = 64'hbad0bad0bad0bad0;
                    rbeat_q.push_back(b);
                end
                b.addr = bus.bmem_addr; b.data = mem_word(bus.bmem_addr, k);
                rbeat_q.push_back(b);
            end
        end
        if (bus.bmem_write) n_wcyc++;
        if (bus.bmem_write && bus.bmem_ready) begin
            if (n_wacc == 0) first_wb_cyc = cyc;
            last_wb_cyc = cyc;
            n_wacc++;
            if (wbeat_q.size() == 0) begin
                chk("unexpected_write", 256'(bus.bmem_write), 256'(0));
            end else begin
                b = wbeat_q.pop_front();
                chk("wr_addr", 256'(bus.bmem_addr), 256'(b.addr));
                chk("wr_data", 256'(bus.bmem_wdata), 256'(b.data));
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_done(input int max_cycles);
        int n = 0;
        while ((resp_q.size() != 0 || rbeat_q.size() != 0 || wbeat_q.size() != 0 ||
                rdcmd_q.size() != 0) && n < max_cycles) begin
            tick();
            n++;
        end
        chk("pending_after_wait", 256'(resp_q.size() + wbeat_q.size() + rdcmd_q.size()), 256'(0));
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "bench did not complete");
    end

    initial begin
        logic [255:0] wd;
        int c0;
        bus.i_addr = '0; bus.i_read = 1'b0;
        bus.d_addr = '0; bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_wdata = '0;
        bus.bmem_ready = 1'b0; bus.bmem_raddr = '0; bus.bmem_rdata = '0; bus.bmem_rvalid = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_bmem_addr",  256'(bus.bmem_addr),  256'(0));
        chk("rst_bmem_read",  256'(bus.bmem_read),  256'(0));
        chk("rst_bmem_write", 256'(bus.bmem_write), 256'(0));
        chk("rst_bmem_wdata", 256'(bus.bmem_wdata), 256'(0));
        chk("rst_resp",       256'({bus.i_resp, bus.d_resp}), 256'(0));
        chk("rst_rdata",      bus.i_rdata | bus.d_rdata, 256'(0));

        // Tie from reset: D first, then I
        rst = 1'b0;
        bus.i_addr = 32'h00001044; bus.i_read = 1'b1;
        bus.d_addr = 32'h00002068; bus.d_read = 1'b1;
        exp_read(1'b1, 32'h00002060, mem_line(32'h00002060));
        exp_read(1'b0, 32'h00001040, mem_line(32'h00001040));
        wait_done(80);

        // Repeat tie: D again, then I
        bus.i_addr = 32'h00003000; bus.i_read = 1'b1;
        bus.d_addr = 32'h00004010; bus.d_read = 1'b1;
        exp_read(1'b1, 32'h00004000, mem_line(32'h00004000));
        exp_read(1'b0, 32'h00003000, mem_line(32'h00003000));
        wait_done(80);

        // I-only read with known beats and latency
        bus.i_addr = 32'h1eceb004; bus.i_read = 1'b1;
        exp_read(1'b0, 32'h1eceb000, LINE_1ECEB);
        c0 = cyc;
        wait_done(40);
        chk("rd_cmd_latency",  256'(cmd_cyc - c0), 256'(1));
        chk("rd_resp_latency", 256'(last_resp_cyc - last_beat_cyc), 256'(1));
        repeat (3) tick();
        chk("rdata_hold", bus.i_rdata, LINE_1ECEB);

        // D writeback, ready held high
        for (int j = 0; j < 8; j++) wd[j*32 +: 32] = $urandom;
        bus.d_addr = 32'h00000080; bus.d_wdata = wd; bus.d_write = 1'b1;
        exp_write(32'h00000080, wd);
        n_wacc = 0; n_wcyc = 0;
        c0 = cyc;
        wait_done(40);
        chk("wr_first_beat_cyc", 256'(first_wb_cyc - c0), 256'(1));
        chk("wr_last_beat_cyc",  256'(last_wb_cyc - c0),  256'(4));
        chk("wr_resp_cyc",       256'(last_resp_cyc - c0), 256'(5));
        chk("wr_beats",          256'(n_wacc), 256'(4));

        // D writeback with ready toggling 1,0,1,0 from the first WR cycle
        for (int j = 0; j < 8; j++) wd[j*32 +: 32] = $urandom;
        bus.d_addr = 32'h000001a4; bus.d_wdata = wd; bus.d_write = 1'b1;
        exp_write(32'h000001a0, wd);
        n_wacc = 0; n_wcyc = 0;
        ready_mode = 1; ready_phase = 1'b0;
        c0 = cyc;
        wait_done(60);
        ready_mode = 0;
        chk("tog_beats",      256'(n_wacc), 256'(4));
        chk("tog_wr_cycles",  256'(n_wcyc), 256'(7));
        chk("tog_resp_cyc",   256'(last_resp_cyc - c0), 256'(8));

        // D read with a foreign-tagged beat in the middle
        inject_bad = 1'b1;
        bus.d_addr = 32'h00000500; bus.d_read = 1'b1;
        exp_read(1'b1, 32'h00000500, mem_line(32'h00000500));
        wait_done(60);
        inject_bad = 1'b0;

        // Reset after two stored beats of an I read
        bus.i_addr = 32'h00007000; bus.i_read = 1'b1;
        rdcmd_q.push_back(32'h00007000);
        rbeats_sent = 0;
        for (int n = 0; n < 20 && rbeats_sent < 2; n++) tick();
        chk("beats_before_rst", 256'(rbeats_sent), 256'(2));
        rst = 1'b1;
        bus.i_read = 1'b0;
        tick();
        rst = 1'b0;
        chk("midrst_bmem_addr", 256'(bus.bmem_addr), 256'(0));
        chk("midrst_bmem_read", 256'(bus.bmem_read), 256'(0));
        chk("midrst_resp",      256'({bus.i_resp, bus.d_resp}), 256'(0));
        chk("midrst_rdata",     bus.i_rdata, 256'(0));
        repeat (6) tick();
        chk("late_beats_drained", 256'(rbeat_q.size()), 256'(0));
        chk("late_beats_ignored", bus.i_rdata, 256'(0));

        // A fresh request after the aborted one completes normally
        bus.i_addr = 32'h00007008; bus.i_read = 1'b1;
        exp_read(1'b0, 32'h00007000, mem_line(32'h00007000));
        wait_done(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
